// File: rtl/lcd_timing_pattern_gen.sv
// Parametrised RGB LCD timing generator with four runtime-selectable test patterns.
// Syncs, DE, pixel coordinates and colour are registered together, one cycle behind the counters.
module lcd_timing_pattern_gen #(
  parameter int unsigned H_ACTIVE  = 800,
  parameter int unsigned H_FP      = 210,
  parameter int unsigned H_SYNC    = 1,
  parameter int unsigned H_BP      = 181,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 45,
  parameter int unsigned V_SYNC    = 5,
  parameter int unsigned V_BP      = 0,
  parameter int unsigned SYNC_POL  = 0,
  parameter int unsigned R_BITS    = 5,
  parameter int unsigned G_BITS    = 6,
  parameter int unsigned B_BITS    = 5,
  parameter int unsigned GRID      = 40,
  parameter int unsigned BALL_SIZE = 32,
  parameter int unsigned BALL_STEP = 4
) (
  input  logic              PixelClk,
  input  logic              Rst,
  input  logic [1:0]        Mode,
  output logic              LCD_HSYNC,
  output logic              LCD_VSYNC,
  output logic              LCD_DE,
  output logic [R_BITS-1:0] LCD_R,
  output logic [G_BITS-1:0] LCD_G,
  output logic [B_BITS-1:0] LCD_B,
  output logic [11:0]       Pixel_X,
  output logic [11:0]       Pixel_Y,
  output logic              Frame_Start
);

  localparam int unsigned CW      = 12;
  localparam int unsigned XW      = 13;
  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned H_START = H_SYNC + H_BP;
  localparam int unsigned V_START = V_SYNC + V_BP;
  localparam int unsigned H_END   = H_START + H_ACTIVE;
  localparam int unsigned V_END   = V_START + V_ACTIVE;
  localparam int unsigned BAR_W   = H_ACTIVE / 8;
  localparam int unsigned BX_MAX  = H_ACTIVE - BALL_SIZE;
  localparam int unsigned BY_MAX  = V_ACTIVE - BALL_SIZE;
  localparam logic              SYNC_ON = 1'(SYNC_POL);
  localparam logic [B_BITS-1:0] B_HALF  = B_BITS'(1) << (B_BITS - 1);

  logic [CW-1:0]     h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [1:0]        mode_q, mode_d;
  logic [2:0]        bar_idx_q, bar_idx_d;
  logic [CW-1:0]     bar_run_q, bar_run_d;
  logic [CW-1:0]     gcol_q, gcol_d, grow_q, grow_d;
  logic [CW-1:0]     ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic              ball_dx_q, ball_dx_d, ball_dy_q, ball_dy_d;
  logic              hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d, fs_q, fs_d;
  logic [R_BITS-1:0] r_q, r_d;
  logic [G_BITS-1:0] g_q, g_d;
  logic [B_BITS-1:0] b_q, b_d;
  logic [CW-1:0]     px_q, px_d, py_q, py_d;
  logic              h_wrap, frame_top, h_act, v_act, act, in_ball;

  // One ball axis: returns {direction_positive, position} for the next frame.
  function automatic logic [CW:0] ball_step(input logic [CW-1:0] pos, input logic dir_pos,
                                            input logic [CW-1:0] lim);
    logic [XW-1:0] nxt;
    nxt = XW'(pos) + XW'(BALL_STEP);
    if (dir_pos) begin
      if (nxt > XW'(lim)) ball_step = {1'b0, lim};
      else                ball_step = {1'b1, nxt[CW-1:0]};
    end else begin
      if (pos < CW'(BALL_STEP)) ball_step = {1'b1, {CW{1'b0}}};
      else                      ball_step = {1'b0, pos - CW'(BALL_STEP)};
    end
  endfunction

  always_comb begin
    h_wrap    = (h_cnt_q == CW'(H_TOTAL - 1));
    h_cnt_d   = h_wrap ? '0 : h_cnt_q + CW'(1);
    v_cnt_d   = v_cnt_q;
    if (h_wrap) v_cnt_d = (v_cnt_q == CW'(V_TOTAL - 1)) ? '0 : v_cnt_q + CW'(1);
    frame_top = (h_cnt_q == '0) && (v_cnt_q == '0);
    h_act     = (XW'(h_cnt_q) >= XW'(H_START)) && (XW'(h_cnt_q) < XW'(H_END));
    v_act     = (XW'(v_cnt_q) >= XW'(V_START)) && (XW'(v_cnt_q) < XW'(V_END));
    act       = h_act && v_act;
    px_d      = act ? h_cnt_q - CW'(H_START) : '0;
    py_d      = act ? v_cnt_q - CW'(V_START) : '0;
    mode_d    = frame_top ? Mode : mode_q;

    // Run-length bar index for the pixel at h_cnt; the last bar absorbs the remainder.
    bar_idx_d = bar_idx_q;
    bar_run_d = bar_run_q;
    if (h_cnt_d == CW'(H_START)) begin
      bar_idx_d = '0;
      bar_run_d = '0;
    end else if (h_act) begin
      if ((bar_run_q == CW'(BAR_W - 1)) && (bar_idx_q != 3'd7)) begin
        bar_idx_d = bar_idx_q + 3'd1;
        bar_run_d = '0;
      end else begin
        bar_run_d = bar_run_q + CW'(1);
      end
    end

    // Grid phase counters: column wraps per line, row wraps per frame.
    gcol_d = gcol_q;
    if (h_cnt_d == CW'(H_START))  gcol_d = '0;
    else if (h_act)               gcol_d = (gcol_q == CW'(GRID - 1)) ? '0 : gcol_q + CW'(1);
    grow_d = grow_q;
    if (h_wrap) begin
      if (v_cnt_d == CW'(V_START)) grow_d = '0;
      else if (v_act)              grow_d = (grow_q == CW'(GRID - 1)) ? '0 : grow_q + CW'(1);
    end

    {ball_dx_d, ball_x_d} = {ball_dx_q, ball_x_q};
    {ball_dy_d, ball_y_d} = {ball_dy_q, ball_y_q};
    if (fs_q) begin
      {ball_dx_d, ball_x_d} = ball_step(ball_x_q, ball_dx_q, CW'(BX_MAX));
      {ball_dy_d, ball_y_d} = ball_step(ball_y_q, ball_dy_q, CW'(BY_MAX));
    end
    in_ball = (XW'(px_d) >= XW'(ball_x_q)) && (XW'(px_d) < XW'(ball_x_q) + XW'(BALL_SIZE)) &&
              (XW'(py_d) >= XW'(ball_y_q)) && (XW'(py_d) < XW'(ball_y_q) + XW'(BALL_SIZE));

    hsync_d = (h_cnt_q < CW'(H_SYNC)) ? SYNC_ON : ~SYNC_ON;
    vsync_d = (v_cnt_q < CW'(V_SYNC)) ? SYNC_ON : ~SYNC_ON;
    de_d    = act;
    fs_d    = frame_top;

    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (act) begin
      case (mode_d)
        2'd0: begin
          r_d = '1; g_d = '1; b_d = '1;
        end
        2'd1: begin
          r_d = {R_BITS{~bar_idx_q[1]}};
          g_d = {G_BITS{~bar_idx_q[2]}};
          b_d = {B_BITS{~bar_idx_q[0]}};
        end
        2'd2: begin
          if ((gcol_q == '0) || (grow_q == '0)) begin
            r_d = '1; g_d = '1; b_d = '1;
          end
        end
        default: begin
          if (in_ball) begin
            r_d = '1; g_d = '1; b_d = '1;
          end else begin
            b_d = B_HALF;
          end
        end
      endcase
    end
  end

  always_ff @(posedge PixelClk or posedge Rst) begin
    if (Rst) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      mode_q    <= '0;
      bar_idx_q <= '0;
      bar_run_q <= '0;
      gcol_q    <= '0;
      grow_q    <= '0;
      ball_x_q  <= '0;
      ball_y_q  <= '0;
      ball_dx_q <= 1'b1;
      ball_dy_q <= 1'b1;
      hsync_q   <= ~SYNC_ON;
      vsync_q   <= ~SYNC_ON;
      de_q      <= 1'b0;
      fs_q      <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      px_q      <= '0;
      py_q      <= '0;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      mode_q    <= mode_d;
      bar_idx_q <= bar_idx_d;
      bar_run_q <= bar_run_d;
      gcol_q    <= gcol_d;
      grow_q    <= grow_d;
      ball_x_q  <= ball_x_d;
      ball_y_q  <= ball_y_d;
      ball_dx_q <= ball_dx_d;
      ball_dy_q <= ball_dy_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      de_q      <= de_d;
      fs_q      <= fs_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      px_q      <= px_d;
      py_q      <= py_d;
    end
  end

  assign LCD_HSYNC   = hsync_q;
  assign LCD_VSYNC   = vsync_q;
  assign LCD_DE      = de_q;
  assign LCD_R       = r_q;
  assign LCD_G       = g_q;
  assign LCD_B       = b_q;
  assign Pixel_X     = px_q;
  assign Pixel_Y     = py_q;
  assign Frame_Start = fs_q;

endmodule

// File: tb/tb_lcd_timing_pattern_gen.sv
// Directed bench for lcd_timing_pattern_gen on a 20x11 smoke raster (plus a 24-wide bar raster).
// Output sample n (n-th edge after reset release) shows counters h = n % H_TOTAL, v = (n / H_TOTAL) % V_TOTAL.
module tb_lcd_timing_pattern_gen;
  localparam int HT = 20;
  localparam int VT = 11;
  localparam int FT = HT * VT;
  localparam int HT2 = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [1:0] mode_bars = 2'd1;

  logic hs0, vs0, de0, fs0, hs1, vs1, de1, fs1, hs2, vs2, de2, fs2;
  logic [4:0] r0, b0, r1, b1, r2, b2;
  logic [5:0] g0, g1, g2;
  logic [11:0] px0, py0, px1, py1, px2, py2;

  int errors = 0;
  int checks = 0;
  int cyc;

  logic [15:0] bar_rgb [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                               16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  int bxs [12] = '{0, 3, 6, 9, 12, 12, 9, 6, 3, 0, 0, 3};
  int bys [4]  = '{0, 3, 4, 1};

  always #5 clk = ~clk;
  always @(posedge clk or posedge rst) if (rst) cyc <= 0; else cyc <= cyc + 1;

  lcd_timing_pattern_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(1), .H_BP(1), .V_ACTIVE(8), .V_FP(1),
    .V_SYNC(1), .V_BP(1), .SYNC_POL(0), .R_BITS(5), .G_BITS(6), .B_BITS(5), .GRID(4),
    .BALL_SIZE(4), .BALL_STEP(3)) u0 (
    .PixelClk(clk), .Rst(rst), .Mode(mode), .LCD_HSYNC(hs0), .LCD_VSYNC(vs0), .LCD_DE(de0),
    .LCD_R(r0), .LCD_G(g0), .LCD_B(b0), .Pixel_X(px0), .Pixel_Y(py0), .Frame_Start(fs0));

  lcd_timing_pattern_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(1), .H_BP(1), .V_ACTIVE(8), .V_FP(1),
    .V_SYNC(1), .V_BP(1), .SYNC_POL(1), .R_BITS(5), .G_BITS(6), .B_BITS(5), .GRID(4),
    .BALL_SIZE(4), .BALL_STEP(3)) u1 (
    .PixelClk(clk), .Rst(rst), .Mode(mode), .LCD_HSYNC(hs1), .LCD_VSYNC(vs1), .LCD_DE(de1),
    .LCD_R(r1), .LCD_G(g1), .LCD_B(b1), .Pixel_X(px1), .Pixel_Y(py1), .Frame_Start(fs1));

  lcd_timing_pattern_gen #(.H_ACTIVE(20), .H_FP(2), .H_SYNC(1), .H_BP(1), .V_ACTIVE(8), .V_FP(1),
    .V_SYNC(1), .V_BP(1), .SYNC_POL(0), .R_BITS(5), .G_BITS(6), .B_BITS(5), .GRID(4),
    .BALL_SIZE(4), .BALL_STEP(3)) u2 (
    .PixelClk(clk), .Rst(rst), .Mode(mode_bars), .LCD_HSYNC(hs2), .LCD_VSYNC(vs2), .LCD_DE(de2),
    .LCD_R(r2), .LCD_G(g2), .LCD_B(b2), .Pixel_X(px2), .Pixel_Y(py2), .Frame_Start(fs2));

  task automatic test_reset();
    rst = 1'b1;
    mode = 2'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({hs0, vs0, de0, fs0} !== 4'b1100) begin
      errors++; $display("FAIL reset_ctl_u0 got=%b exp=1100", {hs0, vs0, de0, fs0});
    end
    checks++;
    if ({r0, g0, b0, px0, py0} !== 40'h0) begin
      errors++; $display("FAIL reset_data_u0 got=%h exp=0", {r0, g0, b0, px0, py0});
    end
    checks++;
    if ({hs1, vs1, de1, fs1} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctl_u1 got=%b exp=0000", {hs1, vs1, de1, fs1});
    end
    rst = 1'b0;
  endtask

  task automatic test_timing();
    int de_line [VT];
    int hs_line [VT];
    int fs_cnt = 0;
    int first_de = -1;
    int idx, h, v;
    logic act;
    logic [43:0] got, exp;
    for (int i = 0; i < VT; i++) begin de_line[i] = 0; hs_line[i] = 0; end
    for (int i = 0; i < 2 * FT; i++) begin
      @(negedge clk);
      idx = cyc - 1; h = idx % HT; v = (idx / HT) % VT;
      act = (h >= 2) && (h < 18) && (v >= 2) && (v < 10);
      exp = {h >= 1, v >= 1, act, (idx % FT) == 0, act ? 16'hFFFF : 16'h0,
             act ? 12'(h - 2) : 12'd0, act ? 12'(v - 2) : 12'd0};
      got = {hs0, vs0, de0, fs0, r0, g0, b0, px0, py0};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL timing_u0 idx=%0d got=%h exp=%h", idx, got, exp);
      end
      got = {hs1, vs1, de1, fs1, r1, g1, b1, px1, py1};
      exp[43:42] = ~exp[43:42];
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL timing_pol1 idx=%0d got=%h exp=%h", idx, got, exp);
      end
      if (fs0) fs_cnt++;
      if (de0 && first_de < 0) first_de = idx;
      if (idx < FT) begin
        if (de0) de_line[v]++;
        if (!hs0) hs_line[v]++;
      end
    end
    for (int i = 0; i < VT; i++) begin
      checks++;
      if (de_line[i] !== ((i >= 2 && i < 10) ? 16 : 0) || hs_line[i] !== 1) begin
        errors++; $display("FAIL line_counts v=%0d de=%0d hs_low=%0d", i, de_line[i], hs_line[i]);
      end
    end
    checks++;
    if (fs_cnt !== 2) begin errors++; $display("FAIL frame_start_count got=%0d exp=2", fs_cnt); end
    checks++;
    if (first_de !== 42) begin errors++; $display("FAIL first_de got=%0d exp=42", first_de); end
  endtask

  task automatic test_mode_switch();
    int idx, h, v, f, x, y;
    logic act;
    logic [16:0] got, exp;
    for (int i = 0; i < 2 * FT; i++) begin
      @(negedge clk);
      idx = cyc - 1; h = idx % HT; v = (idx / HT) % VT; f = idx / FT;
      act = (h >= 2) && (h < 18) && (v >= 2) && (v < 10);
      x = h - 2; y = v - 2;
      exp = {act, 16'h0};
      if (act && (f == 2 || (x % 4) == 0 || (y % 4) == 0)) exp[15:0] = 16'hFFFF;
      got = {de0, r0, g0, b0};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL mode_switch idx=%0d got=%h exp=%h", idx, got, exp);
      end
      if (i == 100) mode = 2'd2;
    end
  endtask

  task automatic test_mid_reset();
    int idx;
    int fs_cnt = 0;
    logic found = 1'b0;
    for (int i = 0; i < FT && !found; i++) begin
      @(negedge clk);
      if ((cyc - 1) % FT == 67) found = 1'b1;
    end
    checks++;
    if (!found || de0 !== 1'b1) begin
      errors++; $display("FAIL mid_reset_pre found=%0d de=%b exp_de=1", found, de0);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({hs0, vs0, de0, fs0, r0, g0, b0, px0, py0} !== {4'b1100, 40'h0}) begin
      errors++; $display("FAIL mid_reset_async got=%h", {hs0, vs0, de0, fs0, r0, g0, b0, px0, py0});
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({hs0, vs0, de0, fs0, r0, g0, b0, px0, py0} !== {4'b1100, 40'h0}) begin
      errors++; $display("FAIL mid_reset_hold got=%h", {hs0, vs0, de0, fs0, r0, g0, b0, px0, py0});
    end
    rst = 1'b0;
    for (int i = 0; i <= FT; i++) begin
      @(negedge clk);
      idx = cyc - 1;
      checks++;
      if (fs0 !== ((idx % FT) == 0)) begin
        errors++; $display("FAIL post_reset_fs idx=%0d got=%b", idx, fs0);
      end
      if (fs0) fs_cnt++;
    end
    checks++;
    if (fs_cnt !== 2) begin errors++; $display("FAIL post_reset_fs_count got=%0d exp=2", fs_cnt); end
  endtask

  task automatic test_bars();
    int idx, h, v, x, bar;
    logic act;
    logic [28:0] got, exp;
    mode = 2'd1;
    idx = cyc - 1;
    for (int i = 0; i < 3 * FT && idx < 3 * FT - 1; i++) begin
      @(negedge clk);
      idx = cyc - 1;
      h = idx % HT2; v = (idx / HT2) % VT; x = h - 2;
      act = (h >= 2) && (h < 22) && (v >= 2) && (v < 10);
      bar = (x < 14) ? x / 2 : 7;
      exp = {act, act ? bar_rgb[bar] : 16'h0, act ? 12'(x) : 12'd0};
      got = {de2, r2, g2, b2, px2};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL bars_w20 idx=%0d got=%h exp=%h", idx, got, exp);
      end
      if (idx >= 2 * FT) begin
        h = idx % HT; v = (idx / HT) % VT; x = h - 2;
        act = (h >= 2) && (h < 18) && (v >= 2) && (v < 10);
        exp[15:0] = act ? bar_rgb[x / 2] : 16'h0;
        checks++;
        if ({r0, g0, b0} !== exp[15:0]) begin
          errors++; $display("FAIL bars_w16 idx=%0d got=%h exp=%h", idx, {r0, g0, b0}, exp[15:0]);
        end
      end
    end
  endtask

  task automatic test_ball();
    int idx, h, v, f, x, y, bx, by, cnt;
    logic act, inb;
    logic [15:0] exp;
    rst = 1'b1;
    mode = 2'd3;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 11 * FT; i++) begin
      @(negedge clk);
      idx = cyc - 1; h = idx % HT; v = (idx / HT) % VT; f = idx / FT;
      act = (h >= 2) && (h < 18) && (v >= 2) && (v < 10);
      x = h - 2; y = v - 2;
      bx = bxs[f + 1]; by = bys[(f + 1) % 4];
      inb = (x >= bx) && (x < bx + 4) && (y >= by) && (y < by + 4);
      exp = !act ? 16'h0 : (inb ? 16'hFFFF : 16'h0010);
      checks++;
      if ({r0, g0, b0} !== exp || {r1, g1, b1} !== exp) begin
        errors++; $display("FAIL ball_pix idx=%0d got=%h/%h exp=%h", idx, {r0, g0, b0}, {r1, g1, b1}, exp);
      end
      if (de0 && r0 == 5'd31) cnt++;
      if ((idx % FT) == FT - 1) begin
        checks++;
        if (cnt !== 16) begin errors++; $display("FAIL ball_area frame=%0d got=%0d exp=16", f, cnt); end
        cnt = 0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_mode_switch();
    test_mid_reset();
    test_bars();
    test_ball();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
